layer_sequencer: RTL and testbench
==================================

Name: layer_sequencer

Overview:
- Game-flow controller that feeds and sequences the scrolling 7-column block-layer pipeline.
- On enable, it pre-fills the layer chain with NUM_LAYERS generated layers via load_layer pulses.
- It then converts player button presses into single-cycle jump_left/jump_right strobes, with the next layer already presented on the layer buses.
- It locks out input while the shift animation runs and halts on jump failure.

Parameters:
- NUM_LAYERS, 5, layers loaded during initial fill.
- FILL_GAP, 4, idle clk cycles after each fill load pulse.
- SHIFT_MS, 250, one_ms_tick count the shift animation is given before the next jump is accepted.
- LFSR_SEED, 16'hACE1, LFSR value after reset or disable; must be non-zero.
- START_COL, 3, initial guaranteed-solid column (0..6).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: rst, synchronous, active-high; clock clk.
- module_en  in  1  game running; low forces IDLE.
- one_ms_tick  in  1  one-cycle pulse every 1 ms.
- btn_left  in  1  synchronized left button level.
- btn_right  in  1  synchronized right button level.
- jump_fail_in  in  1  failure flag from the block datapath.
- load_layer  out  1  one-cycle fill load strobe.
- jump_left  out  1  one-cycle left-jump strobe.
- jump_right  out  1  one-cycle right-jump strobe.
- layer_map  out  [0:6]  next layer solid mask; bit 0 is leftmost.
- block_type  out  [0:6]  1 = stable block, 0 = fragile.
- bonus_map  out  [0:6]  bonus positions.
- busy  out  1  high whenever state != READY.
- init_done  out  1  fill complete; stays high until IDLE.
- jump_count  out  16  accepted jumps; saturates at 16'hFFFF.

Behaviour:
- Reset, or module_en low in any state:
  - state = IDLE, lfsr = LFSR_SEED, safe_col = START_COL.
  - All strobes 0; layer/type/bonus maps 0; init_done = 0; jump_count = 0; busy = 1.
  - Button edge registers are cleared.
- States and transitions:
  - IDLE: moves to GEN when module_en is 1.
  - GEN (1 cycle):
    - Advance the LFSR one step: x^16+x^14+x^13+x^11+1, Fibonacci form, shift-left, new bit into lfsr[0].
    - Update safe_col: +1 if lfsr[15] is 1, else -1. At column 0 always +1; at column 6 always -1.
    - Register the maps from the new lfsr and new safe_col. For c = 0..6:
      - layer_map[c] = lfsr[c] OR (c == safe_col).
      - block_type[c] = lfsr[c+7] OR (c == safe_col).
      - bonus_map[c] per the optional feature.
    - Maps are stable outside GEN.
    - Next state: LOAD while fill_cnt < NUM_LAYERS; otherwise READY, with init_done set.
  - LOAD (1 cycle): load_layer = 1, fill_cnt++, then GAP.
  - GAP: waits FILL_GAP cycles, then GEN.
  - READY:
    - Rising edge of btn_left goes to JUMP_L; rising edge of btn_right goes to JUMP_R.
    - Left wins if both edges arrive in the same cycle.
    - Held levels do not retrigger.
  - JUMP_L / JUMP_R (1 cycle): jump_left or jump_right = 1, jump_count++, then SHIFT.
  - SHIFT: counts one_ms_tick pulses; after SHIFT_MS ticks goes to GEN, which then returns to READY.
  - HALT: all strobes 0; maps frozen; leaves only via IDLE.
- Latency:
  - Button edge sampled in cycle n gives the jump strobe in cycle n+1.
  - From module_en rise, the fill completes (READY) after NUM_LAYERS*(2+FILL_GAP)+2 cycles.
- Lockout:
  - Buttons in any state other than READY are ignored and not queued.
  - An edge arriving during SHIFT must not fire on return to READY.
- jump_fail_in:
  - Sampled high in GEN, LOAD, GAP, READY or SHIFT goes to HALT next cycle.
  - If it coincides with a READY button edge, HALT wins and no strobe is issued.
- At most one of load_layer, jump_left, jump_right is high in any cycle.
- Layer data is valid in the cycle of every strobe.
- The SHIFT tick counter is wide enough for SHIFT_MS and is cleared on SHIFT entry.

Optional Feature:
- Macro: LAYER_SEQ_BONUS_EN.
- Defined: bonus_map[c] = layer_map[c] AND lfsr[c] AND lfsr[c+8], i.e. bonuses appear only on solid blocks.
- Undefined: bonus_map is constant 0 and no bonus logic is synthesized.

Test Plan:
- Fill: rst, then module_en = 1 with default parameters -> exactly 5 load_layer pulses spaced 6 cycles apart; init_done and busy = 0 at cycle 32; the first map is derived from lfsr = next(16'hACE1) with safe_col = 2 or 4.
- Jump: in READY, btn_right rises at cycle n -> jump_right = 1 at n+1 with pre-generated maps stable; jump_count = 1; busy stays 1 for 250 ticks + 1 cycle; maps change exactly once.
- Lockout and priority: both buttons rise together in READY -> only jump_left. Another btn_right edge during SHIFT -> no strobe after returning to READY.
- Safe path: 1000 jumps -> in every layer, layer_map and block_type are 1 at safe_col; safe_col differs by exactly 1 from the previous layer; safe_col never leaves 0..6.
- Fail: jump_fail_in = 1 during SHIFT -> HALT, no further strobes on presses; module_en low then high -> full refill from LFSR_SEED reproduces the identical layer sequence.
- Bonus build: without LAYER_SEQ_BONUS_EN, bonus_map == 0 always; with it defined, bonus_map & ~layer_map == 0 always.

Source files
------------

// File: rtl/layer_sequencer.sv
// Game-flow sequencer: pre-fills the block-layer chain, then turns button edges into jump strobes
// with the next layer already on the buses. Optional bonus generation under LAYER_SEQ_BONUS_EN.
module layer_sequencer #(
  parameter int unsigned NUM_LAYERS = 5,
  parameter int unsigned FILL_GAP   = 4,
  parameter int unsigned SHIFT_MS   = 250,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int unsigned START_COL  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        module_en,
  input  logic        one_ms_tick,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        jump_fail_in,
  output logic        load_layer,
  output logic        jump_left,
  output logic        jump_right,
  output logic [0:6]  layer_map,
  output logic [0:6]  block_type,
  output logic [0:6]  bonus_map,
  output logic        busy,
  output logic        init_done,
  output logic [15:0] jump_count
);

  localparam int unsigned FILL_W = $clog2(NUM_LAYERS + 1);
  localparam int unsigned GAP_W  = (FILL_GAP > 1) ? $clog2(FILL_GAP + 1) : 1;
  localparam int unsigned TICK_W = $clog2(SHIFT_MS + 1);
  localparam int unsigned COL_W  = 3;

  typedef enum logic [3:0] {
    IDLE, GEN, LOAD, GAP, READY, JUMP_L, JUMP_R, SHIFT, HALT
  } state_t;

  state_t              state, state_n;
  logic [15:0]         lfsr, lfsr_n;
  logic [COL_W-1:0]    safe_col, col_n;
  logic [0:6]          layer_n, type_n, safe_mask;
  logic [FILL_W-1:0]   fill_cnt, fill_n;
  logic [GAP_W-1:0]    gap_cnt, gap_n;
  logic [TICK_W-1:0]   tick_cnt, tick_n;
  logic [15:0]         count_n, count_inc;
  logic                init_n;
  logic                btn_left_q, btn_right_q;
  logic                edge_l, edge_r;

  assign edge_l    = btn_left & ~btn_left_q;
  assign edge_r    = btn_right & ~btn_right_q;
  assign count_inc = (jump_count == 16'hFFFF) ? jump_count : jump_count + 16'd1;

`ifdef LAYER_SEQ_BONUS_EN
  logic [0:6] bonus_n;
`else
  assign bonus_map = 7'b0;
`endif

  // Next-state, layer generation and counter updates
  always_comb begin
    state_n   = state;
    lfsr_n    = lfsr;
    col_n     = safe_col;
    layer_n   = layer_map;
    type_n    = block_type;
    safe_mask = 7'b0;
    fill_n    = fill_cnt;
    gap_n     = gap_cnt;
    tick_n    = tick_cnt;
    count_n   = jump_count;
    init_n    = init_done;
`ifdef LAYER_SEQ_BONUS_EN
    bonus_n   = bonus_map;
`endif
    case (state)
      IDLE: state_n = GEN;
      GEN: begin
        lfsr_n = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        // The safe column walks one step per layer and reflects off the edges
        if (safe_col == COL_W'(0))      col_n = COL_W'(1);
        else if (safe_col == COL_W'(6)) col_n = COL_W'(5);
        else if (lfsr_n[15])            col_n = safe_col + COL_W'(1);
        else                            col_n = safe_col - COL_W'(1);
        safe_mask = 7'b1000000 >> col_n;
        layer_n = {lfsr_n[0], lfsr_n[1], lfsr_n[2], lfsr_n[3],
                   lfsr_n[4], lfsr_n[5], lfsr_n[6]} | safe_mask;
        type_n  = {lfsr_n[7], lfsr_n[8], lfsr_n[9], lfsr_n[10],
                   lfsr_n[11], lfsr_n[12], lfsr_n[13]} | safe_mask;
`ifdef LAYER_SEQ_BONUS_EN
        bonus_n = layer_n
                & {lfsr_n[0], lfsr_n[1], lfsr_n[2], lfsr_n[3],
                   lfsr_n[4], lfsr_n[5], lfsr_n[6]}
                & {lfsr_n[8], lfsr_n[9], lfsr_n[10], lfsr_n[11],
                   lfsr_n[12], lfsr_n[13], lfsr_n[14]};
`endif
        if (jump_fail_in) begin
          state_n = HALT;
        end else if (fill_cnt < FILL_W'(NUM_LAYERS)) begin
          state_n = LOAD;
        end else begin
          state_n = READY;
          init_n  = 1'b1;
        end
      end
      LOAD: begin
        fill_n  = fill_cnt + FILL_W'(1);
        gap_n   = '0;
        state_n = jump_fail_in ? HALT : GAP;
      end
      GAP: begin
        if (jump_fail_in)                            state_n = HALT;
        else if (gap_cnt == GAP_W'(FILL_GAP - 1))    state_n = GEN;
        else                                         gap_n = gap_cnt + GAP_W'(1);
      end
      READY: begin
        if (jump_fail_in) begin
          state_n = HALT;
        end else if (edge_l) begin
          state_n = JUMP_L;
          count_n = count_inc;
        end else if (edge_r) begin
          state_n = JUMP_R;
          count_n = count_inc;
        end
      end
      JUMP_L, JUMP_R: begin
        state_n = SHIFT;
        tick_n  = '0;
      end
      SHIFT: begin
        if (jump_fail_in) begin
          state_n = HALT;
        end else if (one_ms_tick) begin
          if (tick_cnt == TICK_W'(SHIFT_MS - 1)) state_n = GEN;
          else                                    tick_n = tick_cnt + TICK_W'(1);
        end
      end
      HALT:    state_n = HALT;
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers; strobes are registered from the next state
  always_ff @(posedge clk) begin
    if (rst || !module_en) begin
      state       <= IDLE;
      lfsr        <= LFSR_SEED;
      safe_col    <= COL_W'(START_COL);
      layer_map   <= 7'b0;
      block_type  <= 7'b0;
      fill_cnt    <= '0;
      gap_cnt     <= '0;
      tick_cnt    <= '0;
      btn_left_q  <= 1'b0;
      btn_right_q <= 1'b0;
      load_layer  <= 1'b0;
      jump_left   <= 1'b0;
      jump_right  <= 1'b0;
      busy        <= 1'b1;
      init_done   <= 1'b0;
      jump_count  <= 16'd0;
`ifdef LAYER_SEQ_BONUS_EN
      bonus_map   <= 7'b0;
`endif
    end else begin
      state       <= state_n;
      lfsr        <= lfsr_n;
      safe_col    <= col_n;
      layer_map   <= layer_n;
      block_type  <= type_n;
      fill_cnt    <= fill_n;
      gap_cnt     <= gap_n;
      tick_cnt    <= tick_n;
      btn_left_q  <= btn_left;
      btn_right_q <= btn_right;
      load_layer  <= (state_n == LOAD);
      jump_left   <= (state_n == JUMP_L);
      jump_right  <= (state_n == JUMP_R);
      busy        <= (state_n != READY);
      init_done   <= init_n;
      jump_count  <= count_n;
`ifdef LAYER_SEQ_BONUS_EN
      bonus_map   <= bonus_n;
`endif
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: timeline-based reference model compared every cycle,
// plus hand-computed literal expectations for the first layer and fill timing.
module tb_layer_sequencer;

  localparam int unsigned NUM_LAYERS = 5;
  localparam int unsigned FILL_GAP   = 4;
  localparam int unsigned SHIFT_MS   = 12;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam int unsigned START_COL  = 3;
  localparam int PER       = 2 + FILL_GAP;
  localparam int READY_CYC = NUM_LAYERS * PER + 2;

  logic clk = 1'b0;
  logic rst, module_en, one_ms_tick, btn_left, btn_right, jump_fail_in;
  logic load_layer, jump_left, jump_right, busy, init_done;
  logic [0:6] layer_map, block_type, bonus_map;
  logic [15:0] jump_count;

  always #5 clk = ~clk;

  layer_sequencer #(
    .NUM_LAYERS(NUM_LAYERS), .FILL_GAP(FILL_GAP), .SHIFT_MS(SHIFT_MS),
    .LFSR_SEED(LFSR_SEED), .START_COL(START_COL)
  ) dut (
    .clk(clk), .rst(rst), .module_en(module_en), .one_ms_tick(one_ms_tick),
    .btn_left(btn_left), .btn_right(btn_right), .jump_fail_in(jump_fail_in),
    .load_layer(load_layer), .jump_left(jump_left), .jump_right(jump_right),
    .layer_map(layer_map), .block_type(block_type), .bonus_map(bonus_map),
    .busy(busy), .init_done(init_done), .jump_count(jump_count)
  );

  typedef enum int {M_OFF, M_FILL, M_READY, M_JUMP, M_SHIFT, M_GENRET, M_HALT} mode_t;

  // Reference model: k counts cycles since enable during the fill timeline
  mode_t       m_mode;
  int          m_k, m_ticks, m_col, m_epoch;
  logic [15:0] m_lfsr, m_count;
  logic [0:6]  m_layer, m_type, m_bonus;
  bit          m_dl, m_init, m_pl, m_pr;
  bit          m_valid = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic model_gen(inout logic [15:0] l, inout int col,
                           output logic [0:6] lay, output logic [0:6] typ, output logic [0:6] bon);
    l = {l[14:0], ^(l & 16'hB400)};
    if (col == 0)      col = 1;
    else if (col == 6) col = 5;
    else               col = l[15] ? col + 1 : col - 1;
    for (int c = 0; c < 7; c++) begin
      lay[c] = l[c] | (c == col);
      typ[c] = l[c + 7] | (c == col);
`ifdef LAYER_SEQ_BONUS_EN
      bon[c] = lay[c] & l[c] & l[c + 8];
`else
      bon[c] = 1'b0;
`endif
    end
  endtask

  always @(posedge clk) begin
    mode_t md;
    int k, tk, col, ep;
    logic [15:0] lf, cnt;
    logic [0:6] lay, typ, bon;
    bit dl, ini, pl, pr, el, er, gen;
    md = m_mode; k = m_k; tk = m_ticks; col = m_col; ep = m_epoch;
    lf = m_lfsr; cnt = m_count; lay = m_layer; typ = m_type; bon = m_bonus;
    dl = m_dl; ini = m_init; pl = m_pl; pr = m_pr;
    if (rst || !module_en) begin
      md = M_OFF; k = 0; tk = 0; col = START_COL; lf = LFSR_SEED; cnt = 16'd0;
      lay = 7'b0; typ = 7'b0; bon = 7'b0; dl = 1'b0; ini = 1'b0; pl = 1'b0; pr = 1'b0;
      if (rst) ep = 0;
    end else begin
      case (md)
        M_OFF: begin md = M_FILL; k = 1; ep = ep + 1; end
        M_FILL: begin
          gen = (k % PER == 1);
          if (gen) model_gen(lf, col, lay, typ, bon);
          if (jump_fail_in) md = M_HALT;
          else if (gen && k == NUM_LAYERS * PER + 1) begin md = M_READY; ini = 1'b1; end
          else k = k + 1;
        end
        M_READY: begin
          el = btn_left && !pl;
          er = btn_right && !pr;
          if (jump_fail_in) md = M_HALT;
          else if (el || er) begin
            md = M_JUMP; dl = el;
            if (cnt != 16'hFFFF) cnt = cnt + 16'd1;
          end
        end
        M_JUMP: begin md = M_SHIFT; tk = 0; end
        M_SHIFT: begin
          if (jump_fail_in) md = M_HALT;
          else if (one_ms_tick) begin
            tk = tk + 1;
            if (tk == SHIFT_MS) md = M_GENRET;
          end
        end
        M_GENRET: begin
          model_gen(lf, col, lay, typ, bon);
          md = jump_fail_in ? M_HALT : M_READY;
        end
        default: ;
      endcase
      pl = btn_left; pr = btn_right;
    end
    m_mode <= md; m_k <= k; m_ticks <= tk; m_col <= col; m_epoch <= ep;
    m_lfsr <= lf; m_count <= cnt; m_layer <= lay; m_type <= typ; m_bonus <= bon;
    m_dl <= dl; m_init <= ini; m_pl <= pl; m_pr <= pr;
    if (rst) m_valid <= 1'b1;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: model comparison every cycle plus literal timing/value pins
  int en_cyc = -1;
  int loads = 0, last_load = 0, n_jumps = 0, idx = 0;
  bit pinned = 1'b0;
  logic [0:6] rec_layer [NUM_LAYERS];
  logic [0:6] rec_type  [NUM_LAYERS];

  always @(negedge clk) begin
    logic [15:0] pl_lf;
    int pl_col;
    logic [0:6] pl_lay, pl_typ, pl_bon;
    bit exp_load;
    if (rst || !module_en) begin en_cyc = -1; loads = 0; last_load = 0; end
    else en_cyc = en_cyc + 1;
    if (m_valid) begin
      if (!pinned) begin
        pinned = 1'b1;
        pl_lf = LFSR_SEED; pl_col = START_COL;
        model_gen(pl_lf, pl_col, pl_lay, pl_typ, pl_bon);
        check("model_first_lfsr", pl_lf, 16'h59C3);
        check("model_first_col", 16'(pl_col), 16'd2);
        check("model_first_layer", 16'(pl_lay), 16'(7'b1110001));
        check("model_first_type", 16'(pl_typ), 16'(7'b1110110));
      end
      exp_load = (m_mode == M_FILL) && (m_k % PER == 2);
      check("load_layer", 16'(load_layer), 16'(exp_load));
      check("jump_left", 16'(jump_left), 16'(m_mode == M_JUMP && m_dl));
      check("jump_right", 16'(jump_right), 16'(m_mode == M_JUMP && !m_dl));
      check("busy", 16'(busy), 16'(m_mode != M_READY));
      check("init_done", 16'(init_done), 16'(m_init));
      check("jump_count", jump_count, m_count);
      check("layer_map", 16'(layer_map), 16'(m_layer));
      check("block_type", 16'(block_type), 16'(m_type));
      check("bonus_map", 16'(bonus_map), 16'(m_bonus));
`ifdef LAYER_SEQ_BONUS_EN
      check("bonus_on_solid", 16'(bonus_map & ~layer_map), 16'd0);
`endif
      if (exp_load) begin
        idx = (m_k - 2) / PER;
        if (m_epoch == 1) begin
          rec_layer[idx] = m_layer;
          rec_type[idx]  = m_type;
        end else begin
          check("refill_layer", 16'(layer_map), 16'(rec_layer[idx]));
          check("refill_type", 16'(block_type), 16'(rec_type[idx]));
        end
      end
      if (en_cyc == 2) begin
        check("first_layer_lit", 16'(layer_map), 16'(7'b1110001));
        check("first_type_lit", 16'(block_type), 16'(7'b1110110));
      end
      if (load_layer === 1'b1) begin
        if (loads == 0) check("first_load_cycle", 16'(en_cyc), 16'd2);
        else            check("load_spacing", 16'(en_cyc - last_load), 16'(PER));
        last_load = en_cyc;
        loads = loads + 1;
      end
      if (en_cyc == READY_CYC - 1) check("busy_before_ready", 16'(busy), 16'd1);
      if (en_cyc == READY_CYC) begin
        check("busy_at_ready", 16'(busy), 16'd0);
        check("init_at_ready", 16'(init_done), 16'd1);
        check("load_total", 16'(loads), 16'(NUM_LAYERS));
      end
      if (jump_left === 1'b1 || jump_right === 1'b1) begin
        check("safe_layer", 16'(layer_map[m_col]), 16'd1);
        check("safe_type", 16'(block_type[m_col]), 16'd1);
        if (n_jumps == 0) check("first_jump_count", jump_count, 16'd1);
        n_jumps = n_jumps + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0) begin
      step();
      n++;
      if (n > budget) begin
        $display("FAIL wait_ready: busy still %b after %0d cycles", busy, budget);
        $fatal(1);
      end
    end
  endtask

  task automatic press(input logic l, input logic r);
    btn_left = l; btn_right = r;
    step();
    step();
    btn_left = 1'b0; btn_right = 1'b0;
    step();
  endtask

  initial begin
    one_ms_tick = 1'b0;
    forever begin
      step();
      one_ms_tick = ~one_ms_tick;
    end
  end

  initial begin
    rst = 1'b1; module_en = 1'b0; btn_left = 1'b0; btn_right = 1'b0; jump_fail_in = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    module_en = 1'b1;
    wait_ready(200);
    repeat (3) step();
    press(1'b0, 1'b1);
    wait_ready(200);
    repeat (2) step();
    press(1'b1, 1'b1);
    repeat (3) step();
    btn_right = 1'b1;
    wait_ready(200);
    repeat (3) step();
    btn_right = 1'b0;
    step();
    for (int i = 0; i < 1000; i++) begin
      press(i % 2 == 0, i % 2 == 1);
      wait_ready(200);
    end
    press(1'b1, 1'b0);
    repeat (2) step();
    jump_fail_in = 1'b1;
    step();
    jump_fail_in = 1'b0;
    repeat (5) step();
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    repeat (5) step();
    module_en = 1'b0;
    repeat (3) step();
    module_en = 1'b1;
    wait_ready(200);
    press(1'b0, 1'b1);
    wait_ready(200);
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
